// File: rtl/alu_cmd_driver.sv
// Initiator for the 4-bit ALU: takes commands on a valid/ready channel, drives registered operands,
// captures Result/Zero into an accumulator and a response channel. ALU_CMD_CHECK_EN builds a result checker.
module alu_cmd_driver #(
  parameter int unsigned OPCNT_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [2:0]         cmd_op,
  input  logic [3:0]         cmd_a,
  input  logic [3:0]         cmd_b,
  input  logic               cmd_use_acc,
  output logic [3:0]         alu_a,
  output logic [3:0]         alu_b,
  output logic [2:0]         alu_op,
  input  logic [3:0]         alu_result,
  input  logic               alu_zero,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [3:0]         rsp_result,
  output logic               rsp_zero,
  output logic [3:0]         acc,
  output logic [OPCNT_W-1:0] op_count,
  output logic               chk_err
);

  typedef enum logic [1:0] {IDLE, DRIVE, RESP} state_t;

  state_t state;

  // One operation at a time: accept -> drive ALU for a full cycle -> hold response until taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cmd_ready  <= 1'b0;
      alu_a      <= 4'd0;
      alu_b      <= 4'd0;
      alu_op     <= 3'd0;
      rsp_valid  <= 1'b0;
      rsp_result <= 4'd0;
      rsp_zero   <= 1'b0;
      acc        <= 4'd0;
      op_count   <= '0;
    end else begin
      case (state)
        IDLE: begin
          cmd_ready <= 1'b1;
          if (cmd_valid && cmd_ready) begin
            alu_a     <= cmd_use_acc ? acc : cmd_a;
            alu_b     <= cmd_b;
            alu_op    <= cmd_op;
            cmd_ready <= 1'b0;
            state     <= DRIVE;
          end
        end
        DRIVE: begin
          rsp_result <= alu_result;
          rsp_zero   <= alu_zero;
          acc        <= alu_result;
          rsp_valid  <= 1'b1;
          state      <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            op_count  <= op_count + OPCNT_W'(1);
            cmd_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ALU_CMD_CHECK_EN
  logic [3:0] exp_result_c;

  // Reference ALU over the registered operands.
  always_comb begin
    exp_result_c = 4'd0;
    case (alu_op)
      3'b000:  exp_result_c = alu_a + alu_b;
      3'b001:  exp_result_c = alu_a - alu_b;
      3'b010:  exp_result_c = alu_a & alu_b;
      3'b011:  exp_result_c = alu_a | alu_b;
      3'b100:  exp_result_c = alu_a ^ alu_b;
      3'b101:  exp_result_c = ~(alu_a & alu_b);
      3'b110:  exp_result_c = ~(alu_a | alu_b);
      default: exp_result_c = (alu_a < alu_b) ? 4'd1 : 4'd0;
    endcase
  end

  // Sticky until reset; sampled at the capture edge only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chk_err <= 1'b0;
    end else if (state == DRIVE &&
                 (alu_result != exp_result_c || alu_zero != (exp_result_c == 4'd0))) begin
      chk_err <= 1'b1;
    end
  end
`else
  assign chk_err = 1'b0;
`endif

endmodule

// File: doc/alu_cmd_driver.md
Name: alu_cmd_driver

Overview:
- Initiator side of the 4-bit ALU operand/opcode interface. Accepts operation commands over a valid/ready channel and drives registered A, B and opcode into the combinational ALU.
- Captures the ALU's Result and Zero, then returns them on a valid/ready response channel.
- Holds a 4-bit accumulator so operations can chain (A = previous result). Sits between the control/test logic and the ALU instance.

Parameters:
- OPCNT_W, 8, width of the completed-operation counter.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  driver can accept a command
- cmd_op  in  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 NAND, 110 NOR, 111 SLT
- cmd_a  in  4  operand A (ignored when cmd_use_acc=1)
- cmd_b  in  4  operand B
- cmd_use_acc  in  1  1 = use accumulator as operand A
- alu_a  out  4  to ALU A
- alu_b  out  4  to ALU B
- alu_op  out  3  to ALU ALUOp
- alu_result  in  4  from ALU Result
- alu_zero  in  1  from ALU Zero
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_result  out  4  captured result
- rsp_zero  out  1  captured zero flag
- acc  out  4  accumulator value
- op_count  out  OPCNT_W  completed responses, wraps at all-ones to 0
- chk_err  out  1  sticky model mismatch (see Optional Feature)

Behaviour:
- Reset (async, rst_n=0):
  - State = IDLE.
  - cmd_ready=0 while rst_n is low; cmd_ready=1 in the first cycle after release.
  - alu_a, alu_b, alu_op, rsp_result, acc = 0; rsp_valid, rsp_zero, chk_err = 0; op_count = 0.
- Reset asserted mid-operation discards the in-flight command with no response.
- FSM, registered: IDLE -> DRIVE -> RESP -> IDLE.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&&cmd_ready at edge T, register alu_op=cmd_op, alu_b=cmd_b, and alu_a = cmd_use_acc ? acc : cmd_a.
  - Go to DRIVE.
- DRIVE (cycle T+1):
  - cmd_ready=0. ALU inputs are stable for a full cycle.
  - At the closing edge, capture rsp_result=alu_result and rsp_zero=alu_zero, load acc=alu_result, go to RESP.
- RESP (from T+2):
  - rsp_valid=1. rsp_result and rsp_zero stay constant until accepted.
  - On rsp_valid&&rsp_ready: rsp_valid->0, op_count+1, go to IDLE.
  - rsp_ready low stalls indefinitely; cmd_ready stays 0 while stalled.
- alu_a, alu_b and alu_op hold their last values outside DRIVE; they change only on command accept.
- Minimum occupancy is 3 cycles per operation (accept, drive, respond with rsp_ready=1). No overlap between operations.
- cmd_use_acc uses acc as it stands at the accept edge, i.e. the result of the previous completed operation.
- Arithmetic reference, all 4-bit:
  - ADD/SUB modulo 16; no carry or borrow is reported.
  - AND/OR/XOR/NAND/NOR are bitwise.
  - SLT is unsigned: result 0001 if A<B, else 0000.
  - Zero = (result==0).
- op_count at all-ones wraps to 0 on the next accepted response.

Optional Feature:
- Macro: ALU_CMD_CHECK_EN.
- Defined:
  - An internal reference model computes the expected result and zero flag from the registered alu_a/alu_b/alu_op during DRIVE.
  - Any mismatch with alu_result/alu_zero at the capture edge sets chk_err=1.
  - chk_err is sticky until reset.
- Undefined: no model logic is built and chk_err is tied to 0.

Test Plan:
- ADD: cmd a=0011, b=0001, op=000, rsp_ready=1 -> alu_* driven in the cycle after accept; rsp_valid 2 cycles after accept with result=0100, zero=0; acc=0100; op_count=1.
- SUB to zero: a=0101, b=0101, op=001 -> result=0000, zero=1. SUB wrap: a=0000, b=0001 -> result=1111, zero=0.
- Chained accumulator: ADD 0011+0001 (acc=0100), then use_acc=1, b=1010, op=100 -> alu_a=0100, result=1110.
- SLT: a=0010, b=0100, op=111 -> 0001. a=0101, b=0011 -> 0000. NAND 1100,1010 -> 0111. NOR 1100,1010 -> 0001.
- Backpressure: rsp_ready=0 for 5 cycles -> rsp_valid held with stable data, cmd_ready=0, op_count unchanged; rsp_ready=1 -> one handshake, cmd_ready=1 next cycle.
- Reset in DRIVE: assert rst_n=0 -> all outputs 0 immediately, no response appears. With ALU_CMD_CHECK_EN, forcing alu_result wrong for ADD 0011+0001 -> chk_err=1 and remains 1 across later correct operations.
